// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline registers.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 31,
    parameter int WAIT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_mem_read,
    input  logic        idex_reg_write,
    input  logic [2:0]  idex_wr_sel,
    input  logic [2:0]  ifid_rs,
    input  logic [2:0]  ifid_rt,
    input  logic        ifid_uses_rs,
    input  logic        ifid_uses_rt,
    input  logic        br_taken,
    input  logic        imem_stall,
    input  logic        dmem_req,
    input  logic        dmem_done,
    input  logic        halt_mem,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
    state_t state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W:0] wait_nxt;
    logic hazard, timeout;
    assign hazard = idex_mem_read & idex_reg_write &
                    ((ifid_uses_rs & (ifid_rs == idex_wr_sel)) | (ifid_uses_rt & (ifid_rt == idex_wr_sel)));
    assign wait_nxt = {1'b0, wait_q} + (WAIT_W+1)'(1);
    assign timeout = (MAX_WAIT != 0) && (int'(wait_nxt) >= MAX_WAIT);
    always_comb begin
        pc_en = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_flush = 1'b0;
        halted = 1'b0;
        mem_err = 1'b0;
        state_d = state_q;
        wait_d = wait_q;
        if (!rst) begin
            if (state_q == RUN && dmem_req && !dmem_done) begin
                state_d = MEM_WAIT;
                wait_d = WAIT_W'(1);
            end else if (state_q == MEM_WAIT && !dmem_done) begin
                wait_d = wait_nxt[WAIT_W-1:0];
                mem_err = timeout;
                state_d = timeout ? HALTED : MEM_WAIT;
            end else if (state_q == RUN || state_q == MEM_WAIT) begin
                // advancing cycle: RUN priority rules 2-6
                state_d = halt_mem ? DRAIN : RUN;
                wait_d = '0;
                ifid_en = !hazard || br_taken || halt_mem;
                idex_en = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                pc_en = !halt_mem && (br_taken || (!hazard && !imem_stall));
                ifid_flush = halt_mem || br_taken || (!hazard && imem_stall);
                idex_flush = halt_mem || br_taken || hazard;
                exmem_flush = halt_mem;
            end else if (state_q == DRAIN) begin
                memwb_en = 1'b1;
                state_d = HALTED;
            end else begin
                halted = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
        end
    end
`ifdef STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    assign stall_d = ((state_q == RUN || state_q == MEM_WAIT) && !pc_en && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else stall_q <= stall_d;
    end
    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif
endmodule
